// File: rtl/window_minmax_tracker_pkg.sv
// Shared types and helpers for the windowed min/max tracker.
package window_minmax_tracker_pkg;

  typedef enum logic [0:0] {
    StEmpty,
    StAccum
  } state_e;

  // Index width for a window; a single-sample window still needs a 1-bit index.
  function automatic int unsigned calc_idxw(input int unsigned window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/mag_compare_n.sv
// Purely combinational N-bit unsigned magnitude comparator.
module mag_compare_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             greater,
  output logic             lesser
);

  assign equal   = (a == b);
  assign greater = (a > b);
  assign lesser  = (a < b);

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks max/min (and first-occurrence index) over fixed windows of accepted samples,
// pulsing out_valid one cycle after each window's last sample.
module window_minmax_tracker
  import window_minmax_tracker_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WINDOW = 8,
  localparam int unsigned IDXW  = calc_idxw(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_max_idx,
  output logic [IDXW-1:0]  out_min_idx,
  output logic [7:0]       out_win_cnt
);

  localparam int unsigned CNTW = IDXW + 1;
  localparam logic [CNTW-1:0] LastCnt = CNTW'(WINDOW - 1);

  state_e           state_q;
  logic [CNTW-1:0]  sample_cnt_q;
  logic [WIDTH-1:0] cur_max_q, cur_min_q;
  logic [IDXW-1:0]  cur_max_idx_q, cur_min_idx_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_max_q, out_min_q;
  logic [IDXW-1:0]  out_max_idx_q, out_min_idx_q;
  logic [7:0]       out_win_cnt_q;

  logic [WIDTH-1:0] max_d, min_d;
  logic [IDXW-1:0]  max_idx_d, min_idx_d;
  logic             max_eq, max_gt, max_lt;
  logic             min_eq, min_gt, min_lt;
  logic             is_last;

  mag_compare_n #(.WIDTH(WIDTH)) u_cmp_max (
    .a       (in_data),
    .b       (cur_max_q),
    .equal   (max_eq),
    .greater (max_gt),
    .lesser  (max_lt)
  );

  mag_compare_n #(.WIDTH(WIDTH)) u_cmp_min (
    .a       (in_data),
    .b       (cur_min_q),
    .equal   (min_eq),
    .greater (min_gt),
    .lesser  (min_lt)
  );

  logic unused_cmp;
  assign unused_cmp = ^{max_eq, max_lt, min_eq, min_gt};

  assign is_last = (sample_cnt_q == LastCnt);

  // Running extremes including the sample presented this cycle; strict compares keep
  // the earliest index on ties.
  always_comb begin
    max_d     = cur_max_q;
    min_d     = cur_min_q;
    max_idx_d = cur_max_idx_q;
    min_idx_d = cur_min_idx_q;
    if (state_q == StEmpty) begin
      max_d     = in_data;
      min_d     = in_data;
      max_idx_d = '0;
      min_idx_d = '0;
    end else begin
      if (max_gt) begin
        max_d     = in_data;
        max_idx_d = sample_cnt_q[IDXW-1:0];
      end
      if (min_lt) begin
        min_d     = in_data;
        min_idx_d = sample_cnt_q[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StEmpty;
      sample_cnt_q  <= '0;
      cur_max_q     <= '0;
      cur_min_q     <= '0;
      cur_max_idx_q <= '0;
      cur_min_idx_q <= '0;
      out_valid_q   <= 1'b0;
      out_max_q     <= '0;
      out_min_q     <= '0;
      out_max_idx_q <= '0;
      out_min_idx_q <= '0;
      out_win_cnt_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (clear) begin
        state_q      <= StEmpty;
        sample_cnt_q <= '0;
      end else if (in_valid) begin
        cur_max_q     <= max_d;
        cur_min_q     <= min_d;
        cur_max_idx_q <= max_idx_d;
        cur_min_idx_q <= min_idx_d;
        if (is_last) begin
          out_valid_q   <= 1'b1;
          out_max_q     <= max_d;
          out_min_q     <= min_d;
          out_max_idx_q <= max_idx_d;
          out_min_idx_q <= min_idx_d;
          out_win_cnt_q <= out_win_cnt_q + 8'd1;
          state_q       <= StEmpty;
          sample_cnt_q  <= '0;
        end else begin
          state_q      <= StAccum;
          sample_cnt_q <= sample_cnt_q + 1'b1;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_max     = out_max_q;
  assign out_min     = out_min_q;
  assign out_max_idx = out_max_idx_q;
  assign out_min_idx = out_min_idx_q;
  assign out_win_cnt = out_win_cnt_q;

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Randomized and directed checks of two tracker instances (WINDOW=4 and WINDOW=1)
// against a sample-buffer reference model.
module tb_window_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       a_valid, b_valid;
  logic [3:0] a_max, a_min, b_max, b_min;
  logic [1:0] a_max_idx, a_min_idx;
  logic [0:0] b_max_idx, b_min_idx;
  logic [7:0] a_wc, b_wc;

  always #5 clk = ~clk;

  window_minmax_tracker #(.WIDTH(4), .WINDOW(4)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (a_valid),
    .out_max     (a_max),
    .out_min     (a_min),
    .out_max_idx (a_max_idx),
    .out_min_idx (a_min_idx),
    .out_win_cnt (a_wc)
  );

  window_minmax_tracker #(.WIDTH(4), .WINDOW(1)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (b_valid),
    .out_max     (b_max),
    .out_min     (b_min),
    .out_max_idx (b_max_idx),
    .out_min_idx (b_min_idx),
    .out_win_cnt (b_wc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffer each window's samples, scan them when the window fills.
  int m_win[2] = '{4, 1};
  int m_cnt[2];
  int m_buf[2][4];
  int m_valid[2], m_max[2], m_min[2], m_maxi[2], m_mini[2], m_wc[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic v, input int d);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0;
      if (r) begin
        m_cnt[k] = 0; m_max[k] = 0; m_min[k] = 0;
        m_maxi[k] = 0; m_mini[k] = 0; m_wc[k] = 0;
      end else if (c) begin
        m_cnt[k] = 0;
      end else if (v) begin
        m_buf[k][m_cnt[k]] = d;
        m_cnt[k]++;
        if (m_cnt[k] == m_win[k]) begin
          m_max[k] = m_buf[k][0]; m_maxi[k] = 0;
          m_min[k] = m_buf[k][0]; m_mini[k] = 0;
          for (int j = 1; j < m_win[k]; j++) begin
            if (m_buf[k][j] > m_max[k]) begin m_max[k] = m_buf[k][j]; m_maxi[k] = j; end
            if (m_buf[k][j] < m_min[k]) begin m_min[k] = m_buf[k][j]; m_mini[k] = j; end
          end
          m_valid[k] = 1;
          m_wc[k] = (m_wc[k] + 1) % 256;
          m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input int d);
    rst = r; clear = c; in_valid = v; in_data = 4'(d);
    @(posedge clk);
    #1;
    model_step(r, c, v, d);
    check_eq("a_valid", 32'(a_valid), m_valid[0]);
    check_eq("a_max", 32'(a_max), m_max[0]);
    check_eq("a_min", 32'(a_min), m_min[0]);
    check_eq("a_max_idx", 32'(a_max_idx), m_maxi[0]);
    check_eq("a_min_idx", 32'(a_min_idx), m_mini[0]);
    check_eq("a_win_cnt", 32'(a_wc), m_wc[0]);
    check_eq("b_valid", 32'(b_valid), m_valid[1]);
    check_eq("b_max", 32'(b_max), m_max[1]);
    check_eq("b_min", 32'(b_min), m_min[1]);
    check_eq("b_max_idx", 32'(b_max_idx), m_maxi[1]);
    check_eq("b_min_idx", 32'(b_min_idx), m_mini[1]);
    check_eq("b_win_cnt", 32'(b_wc), m_wc[1]);
  endtask

  task automatic feed(input int d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1, 9);
    check_eq("reset_valid", 32'(a_valid), 0);
    check_eq("reset_max", 32'(a_max), 0);

    // Basic window.
    feed(3); feed(9); feed(1); feed(7);
    check_eq("basic_valid", 32'(a_valid), 1);
    check_eq("basic_max", 32'(a_max), 9);
    check_eq("basic_max_idx", 32'(a_max_idx), 1);
    check_eq("basic_min", 32'(a_min), 1);
    check_eq("basic_min_idx", 32'(a_min_idx), 2);
    check_eq("basic_win_cnt", 32'(a_wc), 1);
    idle();
    check_eq("pulse_one_cycle", 32'(a_valid), 0);
    check_eq("hold_max", 32'(a_max), 9);

    // Ties keep the earliest index.
    feed(5); feed(5); feed(2); feed(2);
    check_eq("tie_max_idx", 32'(a_max_idx), 0);
    check_eq("tie_min_idx", 32'(a_min_idx), 2);

    // Gapped window A, then window B starting in the out_valid cycle.
    feed(0); idle(); feed(15); idle(); idle(); feed(15); idle(); feed(0);
    check_eq("gap_max_idx", 32'(a_max_idx), 1);
    check_eq("gap_min_idx", 32'(a_min_idx), 0);
    feed(8); feed(8); feed(8); feed(8);
    check_eq("b2b_max", 32'(a_max), 8);
    check_eq("b2b_valid", 32'(a_valid), 1);

    // clear mid-window drops the coincident sample and the partial window.
    feed(4); feed(6);
    step(1'b0, 1'b1, 1'b1, 1);
    check_eq("clear_holds_max", 32'(a_max), 8);
    feed(2); feed(3); feed(4); feed(5);
    check_eq("clear_max_idx", 32'(a_max_idx), 3);
    check_eq("clear_min", 32'(a_min), 2);

    // rst mid-window, then clear coinciding with the completing sample.
    feed(1); feed(2);
    step(1'b1, 1'b0, 1'b1, 3);
    feed(1); feed(2); feed(3);
    step(1'b0, 1'b1, 1'b1, 4);
    check_eq("clear_last_no_valid", 32'(a_valid), 0);

    // 256 back-to-back windows wrap the counter.
    step(1'b1, 1'b0, 0, 0);
    for (int w = 0; w < 256; w++)
      for (int s = 0; s < 4; s++) feed(int'($urandom_range(0, 15)));
    check_eq("wrap_win_cnt", 32'(a_wc), 0);

    // Random mix of gaps, clears and rare resets.
    for (int n = 0; n < 3000; n++) begin
      int p;
      p = int'($urandom_range(0, 99));
      step(p == 0, (p > 0) && (p < 6), p < 75, int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_minmax_tracker.md
Name: window_minmax_tracker

Overview:
- Streaming consumer of magnitude-compare results.
- Accepts one WIDTH-bit sample per valid cycle and tracks the running maximum and minimum over a fixed window of WINDOW accepted samples.
- Records the in-window index of each extreme.
- Emits a one-cycle result pulse per completed window. Sits downstream of the N-bit magnitude comparator datapath, e.g. feeding threshold or alarm logic.

Parameters:
- WIDTH, 4, sample width in bits (>=1)
- WINDOW, 8, accepted samples per window (>=1)
- IDXW, $clog2(WINDOW) with minimum 1, index width (derived, localparam)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous abort of the current window; partial results discarded
- in_valid  in  1  in_data is presented this cycle
- in_data  in  WIDTH  unsigned sample
- out_valid  out  1  one-cycle pulse: window complete
- out_max  out  WIDTH  maximum of the completed window
- out_min  out  WIDTH  minimum of the completed window
- out_max_idx  out  IDXW  index (0-based) of the first occurrence of the max
- out_min_idx  out  IDXW  index of the first occurrence of the min
- out_win_cnt  out  8  completed-window counter, wraps 255->0

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - Internal cur_max = 0, cur_min = 0, cur_max_idx = 0, cur_min_idx = 0, sample_cnt = 0.
  - FSM = EMPTY.
- FSM states:
  - EMPTY: no samples accepted in the current window.
  - ACCUM: 1..WINDOW-1 samples accepted.
- A sample is accepted when in_valid=1 and clear=0. Gaps in in_valid are allowed; state holds across gaps.
- Accept in EMPTY:
  - cur_max = cur_min = in_data.
  - Both indices = 0.
  - sample_cnt = 1.
  - Go to ACCUM, or complete immediately if WINDOW=1.
- Accept in ACCUM, with i = sample_cnt:
  - Compare in_data against cur_max and cur_min using two comparator instances (unsigned).
  - in_data > cur_max: cur_max = in_data, cur_max_idx = i.
  - in_data < cur_min: cur_min = in_data, cur_min_idx = i.
  - Ties do not update, so the earliest index wins.
  - sample_cnt increments.
- Completion: triggered by acceptance of the WINDOW-th sample (sample_cnt == WINDOW-1 before the accept).
  - Next cycle: out_valid=1 and out_* carry results including that final sample.
  - out_win_cnt increments in the same cycle.
  - FSM returns to EMPTY and sample_cnt clears.
  - Latency: 1 cycle from the last accepted sample to out_valid.
- Back-to-back windows: a sample accepted in the cycle out_valid is high belongs to the new window (index 0). No bubble is required; full throughput is 1 sample/cycle.
- Output persistence: out_max, out_min and the index outputs hold their last values until the next completion. out_valid is high for exactly 1 cycle per window.
- clear:
  - Forces EMPTY and sample_cnt = 0.
  - Does not touch out_* or out_win_cnt.
  - Takes priority over in_valid in the same cycle; that sample is dropped.
  - If the completing sample coincides with clear, there is no completion and no out_valid.
- rst takes priority over clear and in_valid.
- rst or clear mid-window: partial data is lost; no out_valid for that window.
- Width rules:
  - Comparisons are unsigned, full WIDTH; no arithmetic on data.
  - sample_cnt width is IDXW+1 where needed to hold WINDOW-1 safely.
  - out_win_cnt wraps modulo 256.

Decomposition:
- Shared package/header: FSM state encodings (EMPTY, ACCUM) and the IDXW derivation helper.
- Sub-module: mag_compare_n (parameter WIDTH; inputs a, b; outputs equal, greater, lesser), purely combinational. Instantiated twice: (in_data vs cur_max) and (in_data vs cur_min).
- All sequencing stays in the top module.

Test Plan:
- WIDTH=4, WINDOW=4: samples 3,9,1,7 on consecutive cycles -> one cycle after 7: out_valid=1, out_max=9, out_max_idx=1, out_min=1, out_min_idx=2, out_win_cnt=1.
- Ties: samples 5,5,2,2 -> out_max=5 idx 0, out_min=2 idx 2 (earliest occurrence kept).
- Back-to-back with gaps:
  - Window A = 0,15,15,0 with idle cycles between samples -> max 15 idx 1, min 0 idx 0.
  - Window B = 8,8,8,8 starting in the out_valid cycle -> second pulse with max=min=8, idx 0/0, out_win_cnt=2.
  - No sample lost.
- clear mid-window: 4,6, clear (with in_valid=1, data 1) -> sample 1 dropped. Then 2,3,4,5 -> out_max=5 idx 3, out_min=2 idx 0. Previous out_* values unchanged until this pulse.
- rst mid-window and clear coinciding with the 4th sample -> no out_valid, all outputs 0 after rst. out_win_cnt wraps 255->0 after 256 windows.
- WINDOW=1: samples 7,2 -> out_valid on each following cycle with max=min=sample, idx 0.
